// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

    // Sequencer states. The encoding is fixed so that waveforms and external
    // checkers can decode state_q without a lookup table.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Default operand/result width for the lab ALU datapath.
    localparam int DEFAULT_WIDTH = 8;

    // Signed overflow of a subtraction, given the operand sign bits and the
    // sign bit of the result. It can only overflow when the operand signs
    // differ, and it has overflowed when the result sign differs from the minuend.
    function automatic logic sub_overflow(input logic a_msb,
                                          input logic b_msb,
                                          input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Full-subtractor cell: computes one bit of x - y - bin and its borrow-out.
// This is the only arithmetic in the serial datapath.
module serial_subtractor_fs (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out of a single-bit subtraction.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~x & bin) | (y & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit
// per clock through a single full-subtractor cell and a borrow flop.
//
// Handshake: start is sampled on a rising edge while the sequencer is IDLE or
// DONE; that edge (the accepting edge) captures a and b. busy is high while
// bits are being processed and start is ignored then. done is a single-cycle
// pulse WIDTH edges after the accepting edge; diff/borrow/overflow are valid
// while done is high and hold until the next completion or reset. A start
// seen in the DONE cycle is accepted immediately (back-to-back operation).
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Sequencer state.
    state_e state_q, state_d;

    // Operand shift registers, partial result, borrow flop and bit counter.
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bflop_q, bflop_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Operand sign bits, kept for the overflow decision at the last bit.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;

    // Registered outputs; these only change on completion or reset.
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    // Full-subtractor cell outputs for the current bit.
    logic             fs_d;
    logic             fs_bout;

    serial_subtractor_fs u_fs (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (bflop_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // State register and datapath flops; reset clears everything, including
    // any partially computed result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            bflop_q  <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            bflop_q  <= bflop_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    // Next-state and datapath update: accept in IDLE/DONE, one bit per edge in RUN.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        bflop_d  = bflop_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Accepting edge: capture operands and start from a clean borrow.
                    sa_d    = a;
                    sb_d    = b;
                    res_d   = '0;
                    bflop_d = 1'b0;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                // Shift the operands right and the new difference bit in at the top.
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                res_d   = {fs_d, res_q[WIDTH-1:1]};
                bflop_d = fs_bout;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    // Last bit: publish the completed result and pulse done.
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    diff_d   = {fs_d, res_q[WIDTH-1:1]};
                    borrow_d = fs_bout;
                    ovf_d    = sub_overflow(a_msb_q, b_msb_q, fs_d);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output mapping; busy is decoded straight from the state register.
    always_comb begin
        busy     = (state_q == ST_RUN);
        done     = done_q;
        diff     = diff_q;
        borrow   = borrow_q;
        overflow = ovf_q;
    end

endmodule
